slc3_mem_responder: RTL and testbench
=====================================

Name: slc3_mem_responder

Overview:
- Memory-side responder for the SLC-3 CPU memory bus.
- Accepts CPU requests on the active-low SRAM-style strobes (Mem_CE/OE/WE/UB/LB) and a 20-bit ADDR.
- Applies a programmable number of wait states, then performs a byte-lane read or write against an internal word array. Completion is signalled on mem_ready.
- Maps the switch bank into address 0x0FFFF, used by the CPU when it loads the PC at start of execution.

Parameters:
- DEPTH, 1024, number of 16-bit words in the internal array; legal addresses are 0..DEPTH-1.
- WAIT_STATES, 2, cycles between request acceptance and completion; range 0..15.
- IO_ADDR, 20'h0FFFF, address of the read-only switch register.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Mem_CE  in  1  chip enable, active-low.
- Mem_OE  in  1  output (read) enable, active-low.
- Mem_WE  in  1  write enable, active-low.
- Mem_UB  in  1  upper byte lane [15:8] enable, active-low.
- Mem_LB  in  1  lower byte lane [7:0] enable, active-low.
- ADDR  in  20  word address from the CPU MAR.
- Data_out  in  16  write data driven by the CPU.
- Switches  in  16  switch bank, returned on reads of IO_ADDR.
- Data_in  out  16  read data returned to the CPU.
- mem_ready  out  1  completion flag, active-high.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, mem_ready=0, Data_in=16'h0000, wait counter=0. Array contents are not cleared. Reset asserted mid-access aborts the access; a pending write is not committed.
- A request is present when Mem_CE=0 and (Mem_OE=0 or Mem_WE=0). If both OE and WE are low, the request is a write.
- FSM states:
  - IDLE: on a request, latch ADDR, Data_out, UB, LB and read/write type. Load counter=WAIT_STATES. Go to WAIT, or to ACCESS if WAIT_STATES=0.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to ACCESS. Strobe changes during WAIT are ignored; the latched values are used.
  - ACCESS (one cycle): a write updates the enabled byte lanes of array[addr]. A read registers the data into Data_in. Go to DONE.
  - DONE: mem_ready=1 and Data_in held stable. Stay while Mem_CE=0. When Mem_CE=1, go to IDLE, dropping mem_ready and holding Data_in at its last value.
- Latency: mem_ready rises WAIT_STATES+2 cycles after the edge that samples the request (IDLE sample edge, WAIT_STATES WAIT cycles, ACCESS, DONE). With WAIT_STATES=0 it rises 2 cycles after sampling.
- A new request is never accepted until the previous one has seen Mem_CE=1. Back-to-back accesses therefore need at least one CE-high cycle.
- Byte lanes:
  - On reads, bytes with a disabled lane return 8'h00.
  - On writes, bytes with a disabled lane are left unchanged.
  - UB=LB=1 completes normally with no array effect and a read value of 0.
- Address decode:
  - ADDR==IO_ADDR: a read returns Switches sampled in the ACCESS cycle; a write is ignored but still completes.
  - ADDR>=DEPTH (other than IO_ADDR): a read returns 0; a write is ignored; the access still completes. No bus error exists.
- Mem_CE=1 in IDLE is a no-op. OE/WE toggling without CE is ignored.

Decomposition:
- Package slc3_mem_pkg:
  - state enum {IDLE, WAIT, ACCESS, DONE} (2 bits);
  - IO_ADDR default constant;
  - localparam for counter width (4).
- Sub-module slc3_sram_array: DEPTH x 16 synchronous array with a registered read, a two-bit byte-write mask and an in-range check. It has no reset. The responder FSM instantiates one.

Test Plan:
- Reset release, WAIT_STATES=2; write 16'hBEEF to 0x00010 with UB=LB=0 and hold CE low -> mem_ready rises 4 cycles after the sample edge. Raise CE, then read 0x00010 -> Data_in=16'hBEEF, mem_ready=1 until CE high.
- Write 16'h1234 to 0x00020 with UB=LB=0. Then write 16'hAB00 with UB=0, LB=1. Read back -> 16'hAB34. Read with UB=1, LB=0 -> 16'h0034.
- Switches=16'h3000; read 0x0FFFF -> Data_in=16'h3000. Write 16'h5555 to 0x0FFFF -> completes, and a later read still returns the Switches value.
- Read 0x00400 with DEPTH=1024 -> completes with Data_in=0. A write there leaves address 0x00000 unchanged.
- OE=0 and WE=0 together at 0x00005, data 16'h00FF -> treated as a write; a readback returns 16'h00FF. Changing ADDR and Data_out during WAIT has no effect.
- Drop Reset during WAIT of a write of 16'hDEAD to 0x00007 -> mem_ready=0 and Data_in=0 immediately. After reset, a read of 0x00007 returns the prior contents (not 16'hDEAD).

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared state type and constants for the SLC-3 memory responder
package slc3_mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_e;
   localparam logic [19:0] IO_ADDR_DEF = 20'h0FFFF;
   localparam int CNT_W = 4;
endpackage

// File: rtl/slc3_sram_array.sv
// slc3_sram_array: DEPTH x 16 word array with byte-lane writes and a registered read
module slc3_sram_array #(
   parameter int DEPTH = 1024
) (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic        re_i,
   input  logic [1:0]  be_i,
   input  logic [19:0] addr_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [15:0]   mem_q [DEPTH];
   logic [15:0]   rdata_q;
   logic          in_range;
   logic [AW-1:0] idx;
   assign in_range = addr_i < 20'(DEPTH);
   assign idx      = addr_i[AW-1:0];
   assign rdata_o  = rdata_q;
   always_ff @(posedge clk_i) begin
      if (we_i && in_range && be_i[1]) mem_q[idx][15:8] <= wdata_i[15:8];
      if (we_i && in_range && be_i[0]) mem_q[idx][7:0] <= wdata_i[7:0];
      if (re_i) rdata_q <= in_range ? mem_q[idx] : 16'h0000;
   end
endmodule

// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder: SRAM-strobe memory responder with wait states and a switch register
module slc3_mem_responder
   import slc3_mem_pkg::*;
#(
   parameter int          DEPTH       = 1024,
   parameter int          WAIT_STATES = 2,
   parameter logic [19:0] IO_ADDR     = IO_ADDR_DEF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_CE,
   input  logic        Mem_OE,
   input  logic        Mem_WE,
   input  logic        Mem_UB,
   input  logic        Mem_LB,
   input  logic [19:0] ADDR,
   input  logic [15:0] Data_out,
   input  logic [15:0] Switches,
   output logic [15:0] Data_in,
   output logic        mem_ready
);
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [19:0]      addr_q;
   logic [15:0]      wdata_q, sw_q, data_q, arr_rdata, rd_val;
   logic [1:0]       be_q;
   logic             wr_q, ready_q, req, is_io;
   assign req       = !Mem_CE && (!Mem_OE || !Mem_WE);
   assign is_io     = addr_q == IO_ADDR;
   assign rd_val    = (is_io ? sw_q : arr_rdata) & {{8{be_q[1]}}, {8{be_q[0]}}};
   assign Data_in   = data_q;
   assign mem_ready = ready_q;
   slc3_sram_array #(.DEPTH(DEPTH)) u_array (
      .clk_i   (Clk),
      .we_i    (state_q == ACCESS && wr_q && !is_io),
      .re_i    (state_q == ACCESS && !wr_q),
      .be_i    (be_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );
   // DONE spends its first cycle loading the registered array read before raising ready
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         sw_q    <= '0;
         data_q  <= '0;
         be_q    <= '0;
         wr_q    <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req) begin
               addr_q  <= ADDR;
               wdata_q <= Data_out;
               be_q    <= {!Mem_UB, !Mem_LB};
               wr_q    <= !Mem_WE;
               cnt_q   <= CNT_W'(WAIT_STATES);
               state_q <= (WAIT_STATES == 0) ? ACCESS : WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_q <= ACCESS;
            end
            ACCESS: begin
               sw_q    <= Switches;
               state_q <= DONE;
            end
            DONE: if (!ready_q) begin
               ready_q <= 1'b1;
               if (!wr_q) data_q <= rd_val;
            end else if (Mem_CE) begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_slc3_mem_responder.sv
// tb_slc3_mem_responder: random bus traffic checked every cycle against a transaction-level model
module tb_slc3_mem_responder;
   localparam int          DEPTH = 1024;
   localparam int          WS    = 2;
   localparam logic [19:0] IO    = 20'h0FFFF;
   logic        Clk = 0, Reset = 1, Mem_CE = 1, Mem_OE = 1, Mem_WE = 1, Mem_UB = 1, Mem_LB = 1;
   logic [19:0] ADDR = '0;
   logic [15:0] Data_out = '0, Switches = '0;
   logic [15:0] Data_in;
   logic        mem_ready;
   int          total = 0, bad = 0, cyc = 0, last_samp = 0, rise_cyc = 0;
   logic        prev_rdy = 0, exp_ready = 0, run = 0;
   logic [15:0] exp_data = 0;
   logic [15:0] m [DEPTH];

   slc3_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .IO_ADDR(IO)) dut (
      .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_out(Data_out),
      .Switches(Switches), .Data_in(Data_in), .mem_ready(mem_ready)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (mem_ready && !prev_rdy) rise_cyc = cyc;
      prev_rdy = mem_ready;
      if (run) begin
         chk("ready", {31'b0, mem_ready}, {31'b0, exp_ready});
         chk("data", {16'b0, Data_in}, {16'b0, exp_data});
      end
   end

   function automatic logic [15:0] model_read(input logic [19:0] a, input bit ub, input bit lb,
                                              input logic [15:0] sw);
      logic [15:0] v;
      v = (a == IO) ? sw : (a < 20'(DEPTH)) ? m[int'(a)] : 16'h0000;
      return v & {{8{!ub}}, {8{!lb}}};
   endfunction

   task automatic model_write(input logic [19:0] a, input bit ub, input bit lb, input logic [15:0] d);
      if (a != IO && a < 20'(DEPTH)) begin
         if (!ub) m[int'(a)][15:8] = d[15:8];
         if (!lb) m[int'(a)][7:0] = d[7:0];
      end
   endtask

   // one full bus transaction; strobes are scrambled once the request has been sampled
   task automatic access(input bit wr, input bit both, input bit ub, input bit lb,
                         input logic [19:0] a, input logic [15:0] d, input int hold);
      logic [15:0] sw;
      sw = Switches;
      Mem_CE = 0; Mem_WE = !wr; Mem_OE = wr ? !both : 1'b0;
      Mem_UB = ub; Mem_LB = lb; ADDR = a; Data_out = d;
      @(posedge Clk); #1;
      last_samp = cyc;
      Mem_UB = 1'($urandom); Mem_LB = 1'($urandom); Mem_OE = 1'($urandom); Mem_WE = 1'($urandom);
      ADDR = 20'($urandom); Data_out = 16'($urandom);
      repeat (WS + 1) begin @(posedge Clk); #1; end
      @(posedge Clk); #1;
      if (wr) model_write(a, ub, lb, d);
      else exp_data = model_read(a, ub, lb, sw);
      exp_ready = 1;
      repeat (hold) begin @(posedge Clk); #1; end
      Mem_CE = 1;
      @(posedge Clk); #1;
      exp_ready = 0;
   endtask

   task automatic idle(input int n);
      Mem_CE = 1;
      repeat (n) begin
         Mem_OE = 1'($urandom); Mem_WE = 1'($urandom); ADDR = 20'($urandom);
         @(posedge Clk); #1;
      end
   endtask

   function automatic logic [19:0] pick_addr();
      int k;
      k = $urandom_range(0, 43);
      return k < 40 ? 20'(k) : k == 40 ? 20'h003FF : k == 41 ? 20'h00400 : k == 42 ? 20'h12345 : IO;
   endfunction

   initial begin
      #2 Reset = 0;
      #1 run = 1;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_ready", {31'b0, mem_ready}, 32'd0);
      chk("rst_data", {16'b0, Data_in}, 32'd0);
      Reset = 1;
      @(posedge Clk); #1;
      access(1, 0, 0, 0, 20'h00010, 16'hBEEF, 1);
      chk("latency", 32'(rise_cyc - last_samp), 32'd4);
      access(0, 0, 0, 0, 20'h00010, 16'h0000, 2);
      chk("rd_beef", {16'b0, Data_in}, 32'h0000BEEF);
      for (int i = 0; i < 40; i++) if (i != 16) access(1, 0, 0, 0, 20'(i), 16'($urandom), 0);
      access(1, 0, 0, 0, 20'h003FF, 16'($urandom), 0);
      access(1, 0, 0, 0, 20'h00020, 16'h1234, 0);
      access(1, 0, 0, 1, 20'h00020, 16'hAB00, 0);
      access(0, 0, 0, 0, 20'h00020, 16'h0000, 0);
      chk("lanes_ab34", {16'b0, Data_in}, 32'h0000AB34);
      access(0, 0, 1, 0, 20'h00020, 16'h0000, 0);
      chk("lanes_0034", {16'b0, Data_in}, 32'h00000034);
      Switches = 16'h3000;
      access(0, 0, 0, 0, IO, 16'h0000, 0);
      chk("io_read", {16'b0, Data_in}, 32'h00003000);
      access(1, 0, 0, 0, IO, 16'h5555, 0);
      access(0, 0, 0, 0, IO, 16'h0000, 0);
      chk("io_write_ignored", {16'b0, Data_in}, 32'h00003000);
      access(1, 0, 0, 0, 20'h00000, 16'hC0DE, 0);
      access(0, 0, 0, 0, 20'h00400, 16'h0000, 0);
      chk("oob_read", {16'b0, Data_in}, 32'h00000000);
      access(1, 0, 0, 0, 20'h00400, 16'h1111, 0);
      access(0, 0, 0, 0, 20'h00000, 16'h0000, 0);
      chk("oob_no_alias", {16'b0, Data_in}, 32'h0000C0DE);
      access(1, 1, 0, 0, 20'h00005, 16'h00FF, 0);
      access(0, 0, 0, 0, 20'h00005, 16'h0000, 0);
      chk("both_low_write", {16'b0, Data_in}, 32'h000000FF);
      access(1, 0, 0, 0, 20'h00007, 16'h0707, 0);
      Mem_CE = 0; Mem_OE = 1; Mem_WE = 0; Mem_UB = 0; Mem_LB = 0; ADDR = 20'h00007; Data_out = 16'hDEAD;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset = 0; exp_ready = 0; exp_data = 0;
      #1;
      chk("abort_ready", {31'b0, mem_ready}, 32'd0);
      chk("abort_data", {16'b0, Data_in}, 32'd0);
      Mem_CE = 1;
      repeat (2) @(posedge Clk);
      #1 Reset = 1;
      @(posedge Clk); #1;
      access(0, 0, 0, 0, 20'h00007, 16'h0000, 0);
      chk("abort_no_commit", {16'b0, Data_in}, 32'h00000707);
      for (int n = 0; n < 300; n++) begin
         idle($urandom_range(0, 2));
         Switches = 16'($urandom);
         access(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), pick_addr(),
                16'($urandom), $urandom_range(0, 3));
      end
      run = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
